// File: rtl/dcmi_dma_burst.sv
// DMA engine between the DCMI word packer and the AHB RAM write port.
// A FIFO feeds bursts of BURST_LEN writes into a circular or one-shot address window.
module dcmi_dma_burst #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          block_en,
  input  logic                          man_mode,
  input  logic                          circ_mode,
  input  logic                          capture_start,
  input  logic                          mcu_rd_dr,
  output logic [DATA_W-1:0]             mcu_rdata,
  input  logic                          dcmi_dw_vld,
  input  logic [DATA_W-1:0]             dcmi_dw_out,
  input  logic [ADDR_W-1:0]             dma_saddr,
  input  logic [ADDR_W-1:0]             dma_len,
  output logic                          ram_wr_req,
  input  logic                          ram_wr_ack,
  output logic [ADDR_W-1:0]             ram_waddr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fifo_empty,
  output logic                          dma_busy,
  output logic                          ovfl_irq_pulse,
  output logic                          half_irq_pulse,
  output logic                          tc_irq_pulse
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BLEN_B  = BW'(BURST_LEN);
  localparam logic [31:0]   BLEN_32 = 32'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;

  state_t            state_q;
  logic [ADDR_W-1:0] waddr_q, rem_q;
  logic [BW-1:0]     beat_q;
  logic              ovfl_q, half_q, tc_q;

  logic              full, empty, req, ack_ok, pop, push, drop;
  logic [31:0]       level32, rem32, thresh;
  logic [ADDR_W-1:0] win_last, rem_dec, waddr_inc;
  logic              half_hit;
  logic [BW-1:0]     beat_inc;

  assign full     = (level_q == DEPTH_L);
  assign empty    = (level_q == '0);
  assign req      = (state_q == S_BURST) & ~man_mode & ~empty;
  assign ack_ok   = req & ram_wr_ack;
  assign pop      = man_mode ? (mcu_rd_dr & ~empty) : ack_ok;
  assign push     = dcmi_dw_vld & (~full | pop);
  assign drop     = dcmi_dw_vld & full & ~pop;

  assign level32  = 32'(level_q);
  assign rem32    = 32'(rem_q);
  assign thresh   = (rem32 < BLEN_32) ? rem32 : BLEN_32;

  // Window arithmetic wraps modulo 2^ADDR_W on purpose.
  assign win_last  = dma_saddr + dma_len - ADDR_W'(1);
  assign waddr_inc = (waddr_q == win_last) ? dma_saddr : waddr_q + ADDR_W'(1);
  assign rem_dec   = rem_q - ADDR_W'(1);
  assign half_hit  = (dma_len >= ADDR_W'(2)) && ((dma_len - rem_dec) == (dma_len >> 1));
  assign beat_inc  = beat_q + BW'(1);

  // Head is gated so an empty FIFO presents zero rather than stale memory.
  assign mcu_rdata      = empty ? '0 : mem_q[rd_ptr_q];
  assign ram_wdata      = mcu_rdata;
  assign ram_wr_req     = req;
  assign ram_waddr      = waddr_q;
  assign fifo_level     = level_q;
  assign fifo_empty     = empty;
  assign dma_busy       = (state_q == S_BURST);
  assign ovfl_irq_pulse = ovfl_q;
  assign half_irq_pulse = half_q;
  assign tc_irq_pulse   = tc_q;

  always_ff @(posedge clk) begin
    if (push && block_en) mem_q[wr_ptr_q] <= dcmi_dw_out;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (!block_en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_DONE;
      waddr_q <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      ovfl_q  <= 1'b0;
      half_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else if (!block_en) begin
      state_q <= S_DONE;
      waddr_q <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      ovfl_q  <= 1'b0;
      half_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      ovfl_q <= drop;
      half_q <= 1'b0;
      tc_q   <= 1'b0;
      if (capture_start) begin
        waddr_q <= dma_saddr;
        rem_q   <= dma_len;
        beat_q  <= '0;
        state_q <= (dma_len == '0) ? S_DONE : S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!man_mode && level32 >= thresh) state_q <= S_BURST;
          end
          S_BURST: begin
            if (man_mode) begin
              state_q <= S_IDLE;
              beat_q  <= '0;
            end else if (ack_ok) begin
              half_q <= half_hit;
              if (rem_q == ADDR_W'(1)) begin
                tc_q   <= 1'b1;
                beat_q <= '0;
                if (circ_mode) begin
                  rem_q   <= dma_len;
                  waddr_q <= dma_saddr;
                  state_q <= S_IDLE;
                end else begin
                  rem_q   <= '0;
                  waddr_q <= waddr_inc;
                  state_q <= S_DONE;
                end
              end else begin
                rem_q   <= rem_dec;
                waddr_q <= waddr_inc;
                if (beat_inc == BLEN_B) begin
                  beat_q  <= '0;
                  state_q <= S_IDLE;
                end else begin
                  beat_q <= beat_inc;
                end
              end
            end
          end
          default: state_q <= S_DONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcmi_dma_burst.sv
// Scoreboard bench for dcmi_dma_burst: expected RAM writes and irq ack indices are
// queued as stimulus is driven, then compared against what the monitor observed.
module tb_dcmi_dma_burst;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          block_en = 1'b1;
  logic          man_mode = 1'b0;
  logic          circ_mode = 1'b0;
  logic          capture_start = 1'b0;
  logic          mcu_rd_dr = 1'b0;
  logic          dcmi_dw_vld = 1'b0;
  logic [DW-1:0] dcmi_dw_out = '0;
  logic [AW-1:0] dma_saddr = '0;
  logic [AW-1:0] dma_len = '0;
  logic          ram_wr_ack = 1'b0;

  logic [DW-1:0] mcu_rdata, ram_wdata;
  logic          ram_wr_req, fifo_empty, dma_busy;
  logic          ovfl_irq_pulse, half_irq_pulse, tc_irq_pulse;
  logic [AW-1:0] ram_waddr;
  logic [$clog2(D):0] fifo_level;

  dcmi_dma_burst #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .BURST_LEN(BL)) dut (
    .clk(clk), .rstn(rstn), .block_en(block_en), .man_mode(man_mode),
    .circ_mode(circ_mode), .capture_start(capture_start), .mcu_rd_dr(mcu_rd_dr),
    .mcu_rdata(mcu_rdata), .dcmi_dw_vld(dcmi_dw_vld), .dcmi_dw_out(dcmi_dw_out),
    .dma_saddr(dma_saddr), .dma_len(dma_len), .ram_wr_req(ram_wr_req),
    .ram_wr_ack(ram_wr_ack), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .fifo_level(fifo_level), .fifo_empty(fifo_empty), .dma_busy(dma_busy),
    .ovfl_irq_pulse(ovfl_irq_pulse), .half_irq_pulse(half_irq_pulse),
    .tc_irq_pulse(tc_irq_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } xfer_t;

  int    checks = 0;
  int    failures = 0;
  xfer_t exp_q[$];
  xfer_t obs_q[$];
  int    obs_tc[$];
  int    obs_half[$];
  int    ack_cnt = 0;

  // Monitor: records completed writes and the ack count at which each pulse appears.
  always @(negedge clk) begin
    if (tc_irq_pulse)   obs_tc.push_back(ack_cnt);
    if (half_irq_pulse) obs_half.push_back(ack_cnt);
    if (ram_wr_req && ram_wr_ack) begin
      obs_q.push_back({ram_waddr, ram_wdata});
      ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_block();
    block_en = 1'b0;
    tick();
    block_en = 1'b1;
    exp_q.delete();
    obs_q.delete();
    obs_tc.delete();
    obs_half.delete();
  endtask

  task automatic capture(input logic [AW-1:0] sa, input logic [AW-1:0] len);
    dma_saddr = sa;
    dma_len = len;
    capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    dcmi_dw_vld = 1'b1;
    dcmi_dw_out = d;
    tick();
    dcmi_dw_vld = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ram_wr_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", ram_wr_req); end
    checks++; if (ram_waddr !== '0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", ram_waddr); end
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    checks++; if (dma_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", dma_busy); end
    checks++; if ({ovfl_irq_pulse, half_irq_pulse, tc_irq_pulse} !== 3'b000) begin
      failures++; $display("FAIL reset_irqs got=%b exp=000", {ovfl_irq_pulse, half_irq_pulse, tc_irq_pulse}); end
    checks++; if (mcu_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mcu_rdata); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_oneshot();
    int base;
    xfer_t x;
    clear_block();
    circ_mode = 1'b0;
    capture(16'h0100, 16'd8);
    base = ack_cnt;
    ram_wr_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x.a = 16'h0100 + AW'(i);
      x.d = $urandom;
      exp_q.push_back(x);
      push_word(x.d);
    end
    for (int c = 0; c < 100 && obs_q.size() < 8; c++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL oneshot_count got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL oneshot_xfer[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++; if (obs_half.size() != 1 || obs_half[0] - base != 4) begin
      failures++; $display("FAIL oneshot_half got_n=%0d exp one pulse after ack 4", obs_half.size()); end
    checks++; if (obs_tc.size() != 1 || obs_tc[0] - base != 8) begin
      failures++; $display("FAIL oneshot_tc got_n=%0d exp one pulse after ack 8", obs_tc.size()); end
    checks++; if (dma_busy !== 1'b0) begin failures++; $display("FAIL oneshot_busy got=%b exp=0", dma_busy); end
    push_word(32'hA5A5_0001);
    repeat (5) tick();
    checks++; if (obs_q.size() != 8) begin failures++; $display("FAIL oneshot_done_noreq got=%0d exp=8", obs_q.size()); end
    checks++; if (fifo_level !== 4'd1) begin failures++; $display("FAIL oneshot_done_level got=%0d exp=1", fifo_level); end
    ram_wr_ack = 1'b0;
  endtask

  task automatic test_circ();
    int base;
    xfer_t x;
    clear_block();
    circ_mode = 1'b1;
    capture(16'h0100, 16'd6);
    base = ack_cnt;
    ram_wr_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      x.a = 16'h0100 + AW'(i % 6);
      x.d = $urandom;
      exp_q.push_back(x);
      push_word(x.d);
    end
    for (int c = 0; c < 100 && obs_q.size() < 12; c++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() != 12) begin failures++; $display("FAIL circ_count got=%0d exp=12", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL circ_xfer[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++; if (obs_half.size() != 2 || obs_half[0] - base != 3 || obs_half[1] - base != 9) begin
      failures++; $display("FAIL circ_half got_n=%0d exp pulses after acks 3,9", obs_half.size()); end
    checks++; if (obs_tc.size() != 2 || obs_tc[0] - base != 6 || obs_tc[1] - base != 12) begin
      failures++; $display("FAIL circ_tc got_n=%0d exp pulses after acks 6,12", obs_tc.size()); end
    ram_wr_ack = 1'b0;
    circ_mode = 1'b0;
  endtask

  task automatic test_stall_ovfl();
    int base;
    xfer_t x;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    clear_block();
    capture(16'h0200, 16'd10);
    base = ack_cnt;
    ram_wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x.a = 16'h0200 + AW'(i);
      x.d = $urandom;
      exp_q.push_back(x);
      push_word(x.d);
    end
    for (int c = 0; c < 10 && !ram_wr_req; c++) tick();
    checks++; if (ram_wr_req !== 1'b1) begin failures++; $display("FAIL stall_req_start got=%b exp=1", ram_wr_req); end
    ram_wr_ack = 1'b1;
    tick();
    tick();
    ram_wr_ack = 1'b0;
    sa = ram_waddr;
    sd = ram_wdata;
    checks++; if (sa !== 16'h0202) begin failures++; $display("FAIL stall_addr got=%h exp=0202", sa); end
    for (int k = 0; k < 6; k++) begin
      x.a = 16'h0204 + AW'(k);
      x.d = $urandom;
      exp_q.push_back(x);
      dcmi_dw_vld = 1'b1;
      dcmi_dw_out = x.d;
      tick();
      checks++;
      if (ram_wr_req !== 1'b1 || ram_waddr !== sa || ram_wdata !== sd) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/%h/%h", k, ram_wr_req, ram_waddr, ram_wdata, sa, sd);
      end
    end
    dcmi_dw_vld = 1'b0;
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL stall_full got=%0d exp=8", fifo_level); end
    push_word(32'hDEAD_BEEF);
    checks++; if (ovfl_irq_pulse !== 1'b1) begin failures++; $display("FAIL ovfl_pulse got=%b exp=1", ovfl_irq_pulse); end
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovfl_level got=%0d exp=8", fifo_level); end
    tick();
    checks++; if (ovfl_irq_pulse !== 1'b0) begin failures++; $display("FAIL ovfl_single got=%b exp=0", ovfl_irq_pulse); end
    ram_wr_ack = 1'b1;
    for (int c = 0; c < 100 && obs_q.size() < 10; c++) tick();
    repeat (3) tick();
    checks++; if (obs_q.size() != 10) begin failures++; $display("FAIL stall_count got=%0d exp=10", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stall_xfer[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    checks++; if (obs_half.size() != 1 || obs_half[0] - base != 5) begin
      failures++; $display("FAIL stall_half got_n=%0d exp one pulse after ack 5", obs_half.size()); end
    checks++; if (obs_tc.size() != 1 || obs_tc[0] - base != 10) begin
      failures++; $display("FAIL stall_tc got_n=%0d exp one pulse after ack 10", obs_tc.size()); end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL stall_empty got=%b exp=1", fifo_empty); end
    ram_wr_ack = 1'b0;
  endtask

  task automatic test_full_push_pop();
    xfer_t x;
    clear_block();
    capture(16'h0300, 16'd9);
    ram_wr_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x.a = 16'h0300 + AW'(i);
      x.d = $urandom;
      exp_q.push_back(x);
      push_word(x.d);
    end
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL fpp_full got=%0d exp=8", fifo_level); end
    checks++; if (ram_wr_req !== 1'b1) begin failures++; $display("FAIL fpp_req got=%b exp=1", ram_wr_req); end
    x.a = 16'h0308;
    x.d = $urandom;
    exp_q.push_back(x);
    dcmi_dw_vld = 1'b1;
    dcmi_dw_out = x.d;
    ram_wr_ack = 1'b1;
    tick();
    dcmi_dw_vld = 1'b0;
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL fpp_level got=%0d exp=8", fifo_level); end
    checks++; if (ovfl_irq_pulse !== 1'b0) begin failures++; $display("FAIL fpp_ovfl got=%b exp=0", ovfl_irq_pulse); end
    for (int c = 0; c < 100 && obs_q.size() < 9; c++) tick();
    repeat (2) tick();
    checks++; if (obs_q.size() != 9) begin failures++; $display("FAIL fpp_count got=%0d exp=9", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL fpp_xfer[%0d] got=%h/%h exp=%h/%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    ram_wr_ack = 1'b0;
  endtask

  task automatic test_man_mode();
    logic [DW-1:0] w [3];
    clear_block();
    capture(16'h0400, 16'd2);
    man_mode = 1'b1;
    ram_wr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      push_word(w[i]);
      checks++; if (ram_wr_req !== 1'b0) begin failures++; $display("FAIL man_req_push[%0d] got=%b exp=0", i, ram_wr_req); end
    end
    checks++; if (fifo_level !== 4'd3) begin failures++; $display("FAIL man_level got=%0d exp=3", fifo_level); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (mcu_rdata !== w[i]) begin failures++; $display("FAIL man_rdata[%0d] got=%h exp=%h", i, mcu_rdata, w[i]); end
      mcu_rd_dr = 1'b1;
      tick();
      mcu_rd_dr = 1'b0;
      checks++; if (ram_wr_req !== 1'b0) begin failures++; $display("FAIL man_req_rd[%0d] got=%b exp=0", i, ram_wr_req); end
    end
    checks++; if (fifo_empty !== 1'b1) begin failures++; $display("FAIL man_empty got=%b exp=1", fifo_empty); end
    mcu_rd_dr = 1'b1;
    tick();
    mcu_rd_dr = 1'b0;
    checks++; if (fifo_level !== '0 || fifo_empty !== 1'b1) begin
      failures++; $display("FAIL man_rd_empty got=%0d/%b exp=0/1", fifo_level, fifo_empty); end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL man_no_writes got=%0d exp=0", obs_q.size()); end
    man_mode = 1'b0;
    ram_wr_ack = 1'b0;
  endtask

  task automatic test_block_en();
    clear_block();
    capture(16'h0500, 16'd16);
    ram_wr_ack = 1'b0;
    for (int i = 0; i < 5; i++) push_word($urandom);
    for (int c = 0; c < 10 && !ram_wr_req; c++) tick();
    checks++; if (ram_wr_req !== 1'b1) begin failures++; $display("FAIL blk_req_before got=%b exp=1", ram_wr_req); end
    checks++; if (ram_waddr !== 16'h0500) begin failures++; $display("FAIL blk_waddr_before got=%h exp=0500", ram_waddr); end
    block_en = 1'b0;
    tick();
    checks++; if (ram_wr_req !== 1'b0) begin failures++; $display("FAIL blk_req got=%b exp=0", ram_wr_req); end
    checks++; if (fifo_level !== '0) begin failures++; $display("FAIL blk_level got=%0d exp=0", fifo_level); end
    checks++; if (ram_waddr !== '0) begin failures++; $display("FAIL blk_waddr got=%h exp=0", ram_waddr); end
    checks++; if (dma_busy !== 1'b0 || fifo_empty !== 1'b1) begin
      failures++; $display("FAIL blk_flags got=%b/%b exp=0/1", dma_busy, fifo_empty); end
    block_en = 1'b1;
    capture(16'h0500, 16'd0);
    ram_wr_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_word($urandom);
      checks++; if (ram_wr_req !== 1'b0) begin failures++; $display("FAIL len0_req[%0d] got=%b exp=0", i, ram_wr_req); end
    end
    repeat (5) tick();
    checks++; if (ram_wr_req !== 1'b0 || obs_q.size() != 0) begin
      failures++; $display("FAIL len0_idle got=%b/%0d exp=0/0", ram_wr_req, obs_q.size()); end
    checks++; if (fifo_level !== 4'd5) begin failures++; $display("FAIL len0_level got=%0d exp=5", fifo_level); end
    ram_wr_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_circ();
    test_stall_ovfl();
    test_full_push_pop();
    test_man_mode();
    test_block_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
